fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FENCE = 1'b1
  } state_t;

  localparam int unsigned PC_INC     = 4;
  // Low PC bits cleared on every redirect target
  localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO holding {pc, instr} entries; head is visible on rdata.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full queue never takes a push, even if the head leaves the same cycle
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC owner, I-cache requester and decode queue with redirect/FENCE.I handling.
// Optional FETCH_QUEUE_BYPASS_EN forwards a hit straight to decode when the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_req,
  input  logic [DATA_WIDTH-1:0] ic_data,
  input  logic                  ic_valid,
  input  logic                  ic_stall,
  output logic                  ic_invalidate,
  input  logic                  redirect,
  input  logic                  fence_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  output logic [DATA_WIDTH-1:0] dec_instr,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  dec_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] target;
  logic [CW-1:0]         count;
  logic [EW-1:0]         head;
  logic                  flush;
  logic                  running;
  logic                  accept;
  logic                  q_valid;
  logic                  bypass;
  logic                  push;
  logic                  pop;

  assign target  = redirect_pc & ~ADDR_WIDTH'(ALIGN_MASK);
  assign flush   = fence_i || redirect;
  assign running = rst_n && (state == RUN);
  // Full gating looks only at the registered count, never at dec_ready
  assign ic_req  = running && (count < CW'(DEPTH));
  assign accept  = ic_req && ic_valid && !flush;
  assign q_valid = running && (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = running && (count == '0) && ic_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !(bypass && dec_ready);
  assign pop  = q_valid && dec_ready && !flush;

  assign ic_addr       = rst_n ? fetch_pc : RESET_PC;
  assign ic_invalidate = rst_n && (state == FENCE);
  assign dec_valid     = q_valid || bypass;

  // Bypass data wins; otherwise head of queue, zero when nothing is presented
  always_comb begin
    dec_instr = '0;
    dec_pc    = '0;
    if (bypass) begin
      dec_instr = ic_data;
      dec_pc    = fetch_pc;
    end else if (q_valid) begin
      dec_instr = head[DATA_WIDTH-1:0];
      dec_pc    = head[EW-1:DATA_WIDTH];
    end
  end

  // FENCE lasts one cycle unless another fence_i arrives; redirects reload the PC in either state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
    end else if (fence_i) begin
      state    <= FENCE;
      fetch_pc <= target;
    end else if (redirect) begin
      state    <= RUN;
      fetch_pc <= target;
    end else begin
      state <= RUN;
      if (accept) fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_INC);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({fetch_pc, ic_data}),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue: expected PCs queued as hits are driven, checked at decode handoff.
module tb_fetch_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] ic_addr;
  logic        ic_req;
  logic [31:0] ic_data;
  logic        ic_valid;
  logic        ic_stall;
  logic        ic_invalidate;
  logic        redirect;
  logic        fence_i;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  fetch_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .RESET_PC   (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ic_addr       (ic_addr),
    .ic_req        (ic_req),
    .ic_data       (ic_data),
    .ic_valid      (ic_valid),
    .ic_stall      (ic_stall),
    .ic_invalidate (ic_invalidate),
    .redirect      (redirect),
    .fence_i       (fence_i),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_ready     (dec_ready)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Cache model returns a word derived from the requested address
  assign ic_data = instr_of(ic_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted decode handoff must match the oldest expected fetch
  always @(negedge clk) begin
    if (rst_n && dec_valid && dec_ready && !redirect && !fence_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: unexpected dec_pc=%h", dec_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dec_pc !== e || dec_instr !== instr_of(e)) begin
          n_err++;
          $display("FAIL sb_entry: got pc=%h instr=%h, want pc=%h instr=%h",
                   dec_pc, dec_instr, e, instr_of(e));
        end
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; ic_valid = 1'b1; ic_stall = 1'b0; redirect = 1'b0;
    fence_i = 1'b0; redirect_pc = '0; dec_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ic_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", ic_req); end
    nxt(); nxt();
    @(negedge clk);
    n_cmp++; if (ic_addr !== 32'h100) begin n_err++; $display("FAIL reset_addr: got %h want 100", ic_addr); end
    n_cmp++; if (dec_valid !== 1'b0 || ic_invalidate !== 1'b0) begin n_err++; $display("FAIL reset_out: dec_valid=%b inv=%b want 0 0", dec_valid, ic_invalidate); end
    n_cmp++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin n_err++; $display("FAIL reset_dec: pc=%h instr=%h want 0 0", dec_pc, dec_instr); end
    nxt();
  endtask

  task automatic restart;
    rst_n = 1'b0; ic_valid = 1'b0; exp_q.delete();
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic test_stream;
    restart();
    dec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ic_valid = 1'b1;
      exp_q.push_back(32'h100 + 32'(4 * k));
      @(negedge clk);
      n_cmp++; if (ic_req !== 1'b1 || ic_addr !== 32'h100 + 32'(4 * k)) begin n_err++; $display("FAIL stream_req%0d: req=%b addr=%h want 1 %h", k, ic_req, ic_addr, 32'h100 + 32'(4 * k)); end
`ifndef FETCH_QUEUE_BYPASS_EN
      n_cmp++; if (dec_valid !== (k > 0)) begin n_err++; $display("FAIL stream_lat%0d: dec_valid=%b want %b", k, dec_valid, k > 0); end
`endif
      nxt();
    end
    ic_valid = 1'b0;
    nxt();
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL stream_drain: dec_valid=%b left=%0d want 0 0", dec_valid, exp_q.size()); end
    nxt();
  endtask

  task automatic test_full;
    restart();
    dec_ready = 1'b0; ic_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'h100 + 32'(4 * k));
      nxt();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (ic_req !== 1'b0 || ic_addr !== 32'h110) begin n_err++; $display("FAIL full_hold%0d: req=%b addr=%h want 0 110", k, ic_req, ic_addr); end
      n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h100) begin n_err++; $display("FAIL full_head%0d: valid=%b pc=%h want 1 100", k, dec_valid, dec_pc); end
      nxt();
    end
    dec_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (ic_req !== 1'b0) begin n_err++; $display("FAIL full_nocomb: req=%b want 0", ic_req); end
    nxt();
    dec_ready = 1'b0;
    exp_q.push_back(32'h110);
    @(negedge clk);
    n_cmp++; if (ic_req !== 1'b1 || ic_addr !== 32'h110) begin n_err++; $display("FAIL full_resume: req=%b addr=%h want 1 110", ic_req, ic_addr); end
    nxt();
    ic_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (ic_req !== 1'b0) begin n_err++; $display("FAIL full_again: req=%b want 0", ic_req); end
    nxt();
    dec_ready = 1'b1;
    repeat (5) nxt();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL full_drain: left=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_miss;
    redirect = 1'b1; redirect_pc = 32'h200; exp_q.delete();
    nxt();
    redirect = 1'b0; ic_stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (ic_addr !== 32'h200 || ic_req !== 1'b1 || dec_valid !== 1'b0) begin n_err++; $display("FAIL miss_hold%0d: addr=%h req=%b valid=%b want 200 1 0", k, ic_addr, ic_req, dec_valid); end
      nxt();
    end
    ic_stall = 1'b0; ic_valid = 1'b1; exp_q.push_back(32'h200);
    nxt();
    ic_valid = 1'b0;
    @(negedge clk);
`ifndef FETCH_QUEUE_BYPASS_EN
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h200) begin n_err++; $display("FAIL miss_fill: valid=%b pc=%h want 1 200", dec_valid, dec_pc); end
`endif
    nxt(); nxt();
  endtask

  task automatic test_redirect;
    dec_ready = 1'b0; ic_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(32'h204 + 32'(4 * k));
      nxt();
    end
    redirect = 1'b1; redirect_pc = 32'h403; exp_q.delete();
    nxt();
    redirect = 1'b0; ic_valid = 1'b0; dec_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL redir_clear: valid=%b want 0", dec_valid); end
    n_cmp++; if (ic_addr !== 32'h400 || ic_req !== 1'b1) begin n_err++; $display("FAIL redir_addr: addr=%h req=%b want 400 1", ic_addr, ic_req); end
    nxt();
    ic_valid = 1'b1; exp_q.push_back(32'h400);
    nxt();
    ic_valid = 1'b0;
    nxt(); nxt();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL redir_drain: left=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_fence;
    fence_i = 1'b1; redirect_pc = 32'h80; exp_q.delete();
    @(negedge clk);
    n_cmp++; if (ic_invalidate !== 1'b0) begin n_err++; $display("FAIL fence_early: inv=%b want 0", ic_invalidate); end
    nxt();
    fence_i = 1'b0; ic_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (ic_invalidate !== 1'b1 || ic_req !== 1'b0 || dec_valid !== 1'b0) begin n_err++; $display("FAIL fence_pulse: inv=%b req=%b valid=%b want 1 0 0", ic_invalidate, ic_req, dec_valid); end
    nxt();
    exp_q.push_back(32'h80);
    @(negedge clk);
    n_cmp++; if (ic_invalidate !== 1'b0 || ic_req !== 1'b1 || ic_addr !== 32'h80) begin n_err++; $display("FAIL fence_resume: inv=%b req=%b addr=%h want 0 1 80", ic_invalidate, ic_req, ic_addr); end
    nxt();
    ic_valid = 1'b0;
    nxt(); nxt();
  endtask

  task automatic test_back_to_back;
    fence_i = 1'b1; redirect_pc = 32'h80; exp_q.delete();
    nxt();
    redirect_pc = 32'h90;
    nxt();
    fence_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (ic_invalidate !== 1'b1) begin n_err++; $display("FAIL b2b_second: inv=%b want 1", ic_invalidate); end
    nxt();
    @(negedge clk);
    n_cmp++; if (ic_invalidate !== 1'b0 || ic_req !== 1'b1 || ic_addr !== 32'h90) begin n_err++; $display("FAIL b2b_resume: inv=%b req=%b addr=%h want 0 1 90", ic_invalidate, ic_req, ic_addr); end
    fence_i = 1'b1; redirect_pc = 32'hA0;
    nxt();
    fence_i = 1'b0; redirect = 1'b1; redirect_pc = 32'hB0;
    nxt();
    redirect = 1'b0;
    @(negedge clk);
    n_cmp++; if (ic_invalidate !== 1'b0 || ic_req !== 1'b1 || ic_addr !== 32'hB0) begin n_err++; $display("FAIL b2b_redir: inv=%b req=%b addr=%h want 0 1 b0", ic_invalidate, ic_req, ic_addr); end
    nxt();
  endtask

  task automatic test_wrap;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; exp_q.delete();
    nxt();
    redirect = 1'b0; ic_valid = 1'b1; exp_q.push_back(32'hFFFF_FFFC);
    @(negedge clk);
    n_cmp++; if (ic_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: addr=%h want fffffffc", ic_addr); end
    nxt();
    ic_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (ic_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next: addr=%h want 0", ic_addr); end
    nxt(); nxt();
  endtask

  task automatic test_bypass;
    redirect = 1'b1; redirect_pc = 32'h300; exp_q.delete();
    nxt();
    redirect = 1'b0; ic_valid = 1'b1; dec_ready = 1'b1; exp_q.push_back(32'h300);
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h300) begin n_err++; $display("FAIL bypass_same: valid=%b pc=%h want 1 300", dec_valid, dec_pc); end
`else
    n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL bypass_off: valid=%b want 0", dec_valid); end
`endif
    nxt();
    ic_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    n_cmp++; if (dec_valid !== 1'b0) begin n_err++; $display("FAIL bypass_empty: valid=%b want 0", dec_valid); end
`else
    n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 32'h300) begin n_err++; $display("FAIL bypass_lat: valid=%b pc=%h want 1 300", dec_valid, dec_pc); end
`endif
    nxt(); nxt();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_miss();
    test_redirect();
    test_fence();
    test_back_to_back();
    test_wrap();
    test_bypass();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL final_queue: left=%0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
